// File: rtl/sctag_stdatarep_pipe.sv
// sctag_stdatarep_pipe: flow-controlled store-data repeater with dual output copies, parity check and transfer count
module sctag_stdatarep_pipe #(
    parameter int WIDTH  = 78,
    parameter int DEPTH  = 2,
    parameter int PARITY = 1
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic [WIDTH-1:0] arbdp_store_data_c2,
    input  logic             arbdp_store_par_c2,
    input  logic             arbdp_store_vld_c2,
    output logic             stdatarep_rdy,
    input  logic             rep_hold,
    output logic [WIDTH-1:0] rep_store_data_out,
    output logic [WIDTH-1:0] sctag_scdata_stdecc_out,
    output logic             stdatarep_vld_out,
    output logic             stdatarep_par_err,
    input  logic             stdatarep_err_clr,
    input  logic             stdatarep_cnt_clr,
    output logic [7:0]       stdatarep_xfer_cnt
);
    logic [DEPTH-1:0] v, adv, ld, p, src_p;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [WIDTH-1:0] copy_b;
    logic             xfer, err_set;

    // A stage moves when the hold is off or any stage ahead of it is empty.
    always_comb begin
        logic go;
        adv = '0;
        go  = ~rep_hold;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v[i] & go;
            go     = go | ~v[i];
        end
    end

    assign stdatarep_rdy = ~v[0] | adv[0];

    always_comb begin
        ld       = '0;
        src_p    = '0;
        ld[0]    = arbdp_store_vld_c2 & stdatarep_rdy;
        src_d[0] = arbdp_store_data_c2;
        src_p[0] = arbdp_store_par_c2;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i]    = adv[i-1];
            src_d[i] = d[i-1];
            src_p[i] = p[i-1];
        end
    end

    assign xfer    = adv[DEPTH-1];
    assign err_set = (PARITY != 0) && xfer && ((^d[DEPTH-1]) ^ p[DEPTH-1]);

    assign rep_store_data_out      = d[DEPTH-1];
    assign sctag_scdata_stdecc_out = copy_b;
    assign stdatarep_vld_out       = v[DEPTH-1];

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            v      <= '0;
            p      <= '0;
            copy_b <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
            stdatarep_par_err  <= 1'b0;
            stdatarep_xfer_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i] <= ld[i] | (v[i] & ~adv[i]);
                if (ld[i]) begin
                    d[i] <= src_d[i];
                    p[i] <= src_p[i];
                end
            end
            // Second physical copy of the output stage, same load enable as copy A.
            if (ld[DEPTH-1]) copy_b <= src_d[DEPTH-1];
            stdatarep_par_err  <= err_set ? 1'b1 : stdatarep_err_clr ? 1'b0 : stdatarep_par_err;
            stdatarep_xfer_cnt <= stdatarep_cnt_clr ? 8'd0 :
                                  (xfer && stdatarep_xfer_cnt != 8'hff) ? stdatarep_xfer_cnt + 8'd1 :
                                  stdatarep_xfer_cnt;
        end
    end
endmodule

// File: tb/tb_sctag_stdatarep_pipe.sv
// tb_sctag_stdatarep_pipe: random and directed stimulus checked against a queue-based model of the repeater
module tb_sctag_stdatarep_pipe;
    localparam int W = 78;
    localparam int D = 2;

    logic         rclk = 1'b0;
    logic         arst_l = 1'b0;
    logic [W-1:0] data = '0;
    logic         par = 1'b0, vld = 1'b0, hold = 1'b0, eclr = 1'b0, cclr = 1'b0;
    logic         rdy, vld_out, par_err;
    logic [W-1:0] out_a, out_b;
    logic [7:0]   cnt;

    sctag_stdatarep_pipe #(.WIDTH(W), .DEPTH(D), .PARITY(1)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .arbdp_store_data_c2(data), .arbdp_store_par_c2(par), .arbdp_store_vld_c2(vld),
        .stdatarep_rdy(rdy), .rep_hold(hold),
        .rep_store_data_out(out_a), .sctag_scdata_stdecc_out(out_b),
        .stdatarep_vld_out(vld_out), .stdatarep_par_err(par_err),
        .stdatarep_err_clr(eclr), .stdatarep_cnt_clr(cclr),
        .stdatarep_xfer_cnt(cnt)
    );

    always #5 rclk = ~rclk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // In-flight words, oldest first, each tagged with the stage it occupies.
    typedef struct {logic [W-1:0] d; logic p; int st;} ent_t;
    ent_t         q[$];
    logic [W-1:0] m_out;
    logic         m_err, m_rdy;
    int           m_cnt;

    function automatic void m_reset();
        q.delete();
        m_out = '0;
        m_err = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    // One clock: drive inputs, compare DUT against model at negedge, commit model at posedge.
    task automatic cyc(input logic v, input logic [W-1:0] dd, input logic pp,
                       input logic h, input logic ec, input logic cc);
        ent_t nq[$];
        logic x, set, at_out, loaded;
        vld = v; data = dd; par = pp; hold = h; eclr = ec; cclr = cc;
        nq = q;
        at_out = q.size() > 0 && q[0].st == D - 1;
        x = at_out && !h;
        set = 1'b0;
        if (x) begin
            set = (^nq[0].d) ^ nq[0].p;
            void'(nq.pop_front());
        end
        for (int i = 0; i < nq.size(); i++)
            if (nq[i].st < D - 1 && (i == 0 || nq[i-1].st != nq[i].st + 1)) nq[i].st++;
        m_rdy = nq.size() == 0 || nq[nq.size()-1].st != 0;
        @(negedge rclk);
        check("rdy", W'(rdy), W'(m_rdy));
        check("vld_out", W'(vld_out), W'(at_out));
        check("copy_a", out_a, m_out);
        check("copy_b", out_b, m_out);
        check("par_err", W'(par_err), W'(m_err));
        check("xfer_cnt", W'(cnt), W'(m_cnt));
        @(posedge rclk);
        if (v && m_rdy) nq.push_back('{dd, pp, 0});
        loaded = nq.size() > 0 && nq[0].st == D - 1 && !(at_out && !x);
        if (loaded) m_out = nq[0].d;
        m_err = set ? 1'b1 : ec ? 1'b0 : m_err;
        m_cnt = cc ? 0 : (x && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        q = nq;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Source that keeps presenting word w until it is taken, then moves on to w+1.
    task automatic feed(input int first, input int last, input int n, input logic h);
        int w = first;
        repeat (n) begin
            logic [W-1:0] dv = W'(w);
            cyc(w <= last, dv, ^dv, h, 1'b0, 1'b0);
            if (w <= last && m_rdy) w++;
        end
    endtask

    initial begin
        logic [W-1:0] pend;
        logic         pend_p, have;
        m_reset();
        #12;
        check("rst_vld", W'(vld_out), '0);
        check("rst_a", out_a, '0);
        check("rst_b", out_b, '0);
        check("rst_rdy", W'(rdy), W'(1'b1));
        check("rst_cnt", W'(cnt), '0);
        @(posedge rclk); #1;
        arst_l = 1'b1;

        feed(1, 4, 8, 1'b0);
        check("stream_cnt", W'(cnt), W'(4));

        feed(1, 3, 6, 1'b1);
        feed(4, 3, 6, 1'b0);

        cyc(1'b1, W'(10), ^W'(10), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, W'(11), ^W'(11), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bubble_rdy", W'(rdy), '0);
        check("bubble_out", out_a, W'(10));
        idle(4);

        cyc(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        feed(2, 4, 5, 1'b0);
        check("perr_sticky", W'(par_err), W'(1'b1));
        cyc(1'b1, W'(7), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        repeat (300) begin
            pend = rnd();
            cyc(1'b1, pend, ^pend, 1'b0, 1'b0, 1'b0);
        end
        check("cnt_sat", W'(cnt), W'(255));
        cyc(1'b1, W'(5), ^W'(5), 1'b0, 1'b0, 1'b1);
        idle(1);

        have = 1'b0;
        pend = '0;
        pend_p = 1'b0;
        repeat (2000) begin
            if (!have && $urandom_range(9) < 7) begin
                pend = rnd();
                pend_p = (^pend) ^ ($urandom_range(9) == 0);
                have = 1'b1;
            end
            cyc(have, pend, pend_p, $urandom_range(9) < 3, $urandom_range(19) == 0,
                $urandom_range(49) == 0);
            if (have && m_rdy) have = 1'b0;
        end

        feed(100, 104, 4, 1'b1);
        #3 arst_l = 1'b0;
        #1;
        check("arst_vld", W'(vld_out), '0);
        check("arst_a", out_a, '0);
        check("arst_b", out_b, '0);
        check("arst_rdy", W'(rdy), W'(1'b1));
        check("arst_err", W'(par_err), '0);
        check("arst_cnt", W'(cnt), '0);
        m_reset();
        @(posedge rclk); #1;
        arst_l = 1'b1;
        feed(200, 203, 8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
